// File: rtl/pixel_core_scheduler_if.sv
// pixel_core_scheduler_if
// Bundles the scheduler's two handshake buses: the job/result bus to the
// iteration cores and the AXI4-Stream pixel output to the video packer.
//   core_req_valid/ready  per-core job handshake (one-hot valid)
//   core_req_x/y          shared job coordinates, qualified by core_req_valid
//   core_res_valid/ready  per-core result handshake
//   core_res_data         packed results, core k at [k*RES_W +: RES_W]
//   out_t*                pixel stream (tuser = SOF, tlast = EOL)
// Modports: master = scheduler side, slave = cores plus stream sink side.
interface pixel_core_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int RES_W     = 24
);
    logic [NUM_CORES-1:0]       core_req_valid;
    logic [NUM_CORES-1:0]       core_req_ready;
    logic [9:0]                 core_req_x;
    logic [8:0]                 core_req_y;
    logic [NUM_CORES-1:0]       core_res_valid;
    logic [NUM_CORES*RES_W-1:0] core_res_data;
    logic [NUM_CORES-1:0]       core_res_ready;
    logic [RES_W-1:0]           out_tdata;
    logic                       out_tvalid;
    logic                       out_tready;
    logic                       out_tuser;
    logic                       out_tlast;

    modport master (
        output core_req_valid, core_req_x, core_req_y, core_res_ready,
        output out_tdata, out_tvalid, out_tuser, out_tlast,
        input  core_req_ready, core_res_valid, core_res_data, out_tready
    );

    modport slave (
        input  core_req_valid, core_req_x, core_req_y, core_res_ready,
        input  out_tdata, out_tvalid, out_tuser, out_tlast,
        output core_req_ready, core_res_valid, core_res_data, out_tready
    );
endinterface

// File: rtl/pixel_core_scheduler.sv
// pixel_core_scheduler
// Walks a frame in raster order, hands each pixel to the iteration cores in
// strict round-robin order and retires results in that same order, so the
// pixel stream leaves in raster order with SOF on the first pixel and EOL on
// the last pixel of every line.
//   clk, rst         clock, asynchronous active-high reset (shared with cores)
//   i_enable         level; high renders frames back-to-back
//   bus              pixel_core_scheduler_if.master (core jobs/results, stream)
//   o_busy           scheduler not idle
//   o_frame_count    completed frames, wraps naturally
//   o_err_spurious   sticky: a core presented a result with no job pending
module pixel_core_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int RES_W     = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    pixel_core_scheduler_if.master        bus,
    output logic                          o_busy,
    output logic [15:0]                   o_frame_count,
    output logic                          o_err_spurious
);
    localparam int                   PTR_W    = $clog2(NUM_CORES);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(NUM_CORES - 1);
    localparam logic [9:0]           X_LAST   = 10'(X_SIZE - 1);
    localparam logic [8:0]           Y_LAST   = 9'(Y_SIZE - 1);
    localparam logic [NUM_CORES-1:0] ONE      = NUM_CORES'(1);

    // Coordinates are carried in fixed 10/9-bit fields.
    generate
        if (NUM_CORES < 2 || NUM_CORES > 16 || X_SIZE < 1 || X_SIZE > 1024 ||
            Y_SIZE < 1 || Y_SIZE > 512) begin : g_param_check
            $error("pixel_core_scheduler: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_ip;
    logic [PTR_W-1:0]     r_rp;
    logic [9:0]           r_ix;
    logic [8:0]           r_iy;
    logic [NUM_CORES-1:0] r_pending;
    logic [9:0]           r_tag_x [NUM_CORES];
    logic [8:0]           r_tag_y [NUM_CORES];
    logic [RES_W-1:0]     r_tdata;
    logic                 r_tvalid;
    logic                 r_tuser;
    logic                 r_tlast;
    logic [15:0]          r_frame_count;
    logic                 r_err;

    logic                 w_req_open;
    logic                 w_issue;
    logic                 w_last_issue;
    logic                 w_can_load;
    logic                 w_retire;
    logic                 w_frame_done;
    logic                 w_start_frame;
    logic [NUM_CORES-1:0] w_issue_mask;
    logic [NUM_CORES-1:0] w_retire_mask;
    logic [RES_W-1:0]     w_res_sel;

    // Only the core under the issue pointer is offered a job, and only once
    // its previous result has retired.
    assign w_req_open    = (r_state == S_RUN) && !r_pending[r_ip];
    assign w_issue       = w_req_open && bus.core_req_ready[r_ip];
    assign w_last_issue  = w_issue && (r_ix == X_LAST) && (r_iy == Y_LAST);
    assign w_issue_mask  = ONE << r_ip;
    assign w_retire_mask = ONE << r_rp;

    // The output register may load when empty or when its beat leaves now.
    assign w_can_load    = !r_tvalid || bus.out_tready;
    assign w_retire      = r_pending[r_rp] && w_can_load && bus.core_res_valid[r_rp];
    assign w_res_sel     = bus.core_res_data[int'(r_rp) * RES_W +: RES_W];
    assign w_start_frame = (r_state != S_RUN) && (w_state_next == S_RUN);

    assign bus.core_req_valid = w_req_open ? w_issue_mask : '0;
    assign bus.core_req_x     = r_ix;
    assign bus.core_req_y     = r_iy;
    assign bus.core_res_ready = (r_pending[r_rp] && w_can_load) ? w_retire_mask : '0;
    assign bus.out_tdata      = r_tdata;
    assign bus.out_tvalid     = r_tvalid;
    assign bus.out_tuser      = r_tuser;
    assign bus.out_tlast      = r_tlast;
    assign o_busy             = (r_state != S_IDLE);
    assign o_frame_count      = r_frame_count;
    assign o_err_spurious     = r_err;

    // Next-state logic. A frame ends only once every job has retired and the
    // last beat has left the stream, so dropping enable never truncates one.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_enable) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_last_issue) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_pending == '0 && !r_tvalid) begin
                    w_frame_done = 1'b1;
                    w_state_next = i_enable ? S_RUN : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, issue side and job bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ip          <= '0;
            r_ix          <= '0;
            r_iy          <= '0;
            r_pending     <= '0;
            r_frame_count <= '0;
            r_err         <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) begin
                r_tag_x[k] <= '0;
                r_tag_y[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_tag_x[r_ip] <= r_ix;
                r_tag_y[r_ip] <= r_iy;
                r_ip          <= (r_ip == LAST_PTR) ? '0 : r_ip + 1'b1;
                if (r_ix == X_LAST) begin
                    r_ix <= '0;
                    r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + 1'b1;
                end else begin
                    r_ix <= r_ix + 1'b1;
                end
            end
            if (w_start_frame) begin
                r_ix <= '0;
                r_iy <= '0;
            end
            // Issue and retire never hit the same core in one cycle: issue needs
            // the pending bit clear, retire needs it set.
            r_pending <= (r_pending & ~(w_retire ? w_retire_mask : '0)) |
                         (w_issue ? w_issue_mask : '0);
            if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
            if (|(bus.core_res_valid & ~r_pending)) r_err <= 1'b1;
        end
    end

    // Retire side: the output register holds while stalled and empties after
    // acceptance unless a new result replaces it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rp     <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_retire) begin
            r_tdata  <= w_res_sel;
            r_tvalid <= 1'b1;
            r_tuser  <= (r_tag_x[r_rp] == '0) && (r_tag_y[r_rp] == '0);
            r_tlast  <= (r_tag_x[r_rp] == X_LAST);
            r_rp     <= (r_rp == LAST_PTR) ? '0 : r_rp + 1'b1;
        end else if (r_tvalid && bus.out_tready) begin
            r_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pixel_core_scheduler.sv
// tb_pixel_core_scheduler
// Drives pixel_core_scheduler with behavioural iteration cores (configurable or
// random latency) and a randomly stalling stream sink. The reference is the
// frame itself: beat n of a frame must carry pixel (n % X, n / X), issue n must
// go to core n % NUM_CORES with the same raster coordinates, and only the core
// holding the oldest outstanding job may be offered result-ready.
module tb_pixel_core_scheduler;
    localparam int NC    = 4;
    localparam int XS    = 8;
    localparam int YS    = 4;
    localparam int RW    = 24;
    localparam int FRAME = XS * YS;
    localparam int BUDGET = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] frameCount;
    logic        errSpurious;

    pixel_core_scheduler_if #(.NUM_CORES(NC), .RES_W(RW)) bus ();

    pixel_core_scheduler #(
        .NUM_CORES(NC), .X_SIZE(XS), .Y_SIZE(YS), .RES_W(RW)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(enable), .bus(bus),
        .o_busy(busy), .o_frame_count(frameCount), .o_err_spurious(errSpurious)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Core models: one job per core, result valid once its latency has elapsed.
    bit      coreBusy [NC];
    int      coreX [NC];
    int      coreY [NC];
    int      coreCnt [NC];
    int      fixedLat [NC];
    int      issuedCores [$];
    int      issueCount;
    int      beatCount;
    bit      randReady;
    int      treadyPct;
    bit      injectSpur;
    bit      spurThisCycle;
    bit      expErr;
    bit      holdFlag;
    logic [RW-1:0] holdData;
    logic    holdUser;
    logic    holdLast;
    bit      reqHs [NC];
    bit      resHs [NC];
    int      issX;
    int      issY;

    function automatic logic [RW-1:0] pix(int x, int y);
        logic [9:0] xv;
        logic [8:0] yv;
        xv = 10'(x);
        yv = 9'(y);
        return {4'h5, 1'b0, yv, xv};
    endfunction

    task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs();
        for (int k = 0; k < NC; k++) begin
            bus.core_req_ready[k] = !coreBusy[k] && (!randReady || $urandom_range(3, 0) != 0);
            bus.core_res_valid[k] = coreBusy[k] && (coreCnt[k] == 0);
            bus.core_res_data[k*RW +: RW] = pix(coreX[k], coreY[k]);
        end
        if (injectSpur) bus.core_res_valid[2] = 1'b1;
        bus.out_tready = ($urandom_range(99, 0) < treadyPct);
    endtask

    task automatic clearModels();
        for (int k = 0; k < NC; k++) begin
            coreBusy[k] = 1'b0;
            coreX[k]    = 0;
            coreY[k]    = 0;
            coreCnt[k]  = 0;
            reqHs[k]    = 1'b0;
            resHs[k]    = 1'b0;
        end
        issuedCores.delete();
        issueCount    = 0;
        beatCount     = 0;
        expErr        = 1'b0;
        holdFlag      = 1'b0;
        injectSpur    = 1'b0;
        spurThisCycle = 1'b0;
    endtask

    // Observes one cycle at the falling edge: handshakes that will complete
    // at the next rising edge, plus stream and status checks.
    task automatic checkOutput();
        logic [NC-1:0] rv;
        logic [NC-1:0] rr;
        logic [NC-1:0] expRr;
        int b;
        rv = bus.core_req_valid;
        rr = bus.core_res_ready;
        if (rv != '0) checkVal("req_onehot", 32'($countones(rv)), 1);
        for (int k = 0; k < NC; k++) begin
            reqHs[k] = rv[k] && bus.core_req_ready[k];
            if (reqHs[k]) begin
                checkVal("issue_core", k, issueCount % NC);
                checkVal("issue_x", 32'(bus.core_req_x), (issueCount % FRAME) % XS);
                checkVal("issue_y", 32'(bus.core_req_y), (issueCount % FRAME) / XS);
                issX = int'(bus.core_req_x);
                issY = int'(bus.core_req_y);
            end
        end
        if (rr != '0) begin
            expRr = (issuedCores.size() > 0) ? (NC'(1) << issuedCores[0]) : '0;
            checkVal("retire_order", 32'(rr), 32'(expRr));
        end
        for (int k = 0; k < NC; k++) resHs[k] = rr[k] && bus.core_res_valid[k];
        if (holdFlag) begin
            checkVal("hold_valid", 32'(bus.out_tvalid), 1);
            checkVal("hold_data", 32'(bus.out_tdata), 32'(holdData));
            checkVal("hold_user", 32'(bus.out_tuser), 32'(holdUser));
            checkVal("hold_last", 32'(bus.out_tlast), 32'(holdLast));
        end
        holdFlag = bus.out_tvalid && !bus.out_tready;
        holdData = bus.out_tdata;
        holdUser = bus.out_tuser;
        holdLast = bus.out_tlast;
        if (bus.out_tvalid && bus.out_tready) begin
            b = beatCount % FRAME;
            checkVal("beat_data", 32'(bus.out_tdata), 32'(pix(b % XS, b / XS)));
            checkVal("beat_tuser", 32'(bus.out_tuser), 32'(b == 0));
            checkVal("beat_tlast", 32'(bus.out_tlast), 32'((b % XS) == XS - 1));
            if (b == 0 && beatCount > 0)
                checkVal("frame_count_at_sof", 32'(frameCount), beatCount / FRAME);
            beatCount++;
        end
        checkVal("err_spurious", 32'(errSpurious), 32'(expErr));
        spurThisCycle = injectSpur;
    endtask

    task automatic updateModels();
        for (int k = 0; k < NC; k++) begin
            if (resHs[k]) begin
                coreBusy[k] = 1'b0;
                if (issuedCores.size() > 0) void'(issuedCores.pop_front());
            end else if (coreBusy[k] && coreCnt[k] > 0) begin
                coreCnt[k]--;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (reqHs[k]) begin
                coreBusy[k] = 1'b1;
                coreX[k]    = issX;
                coreY[k]    = issY;
                coreCnt[k]  = ((fixedLat[k] != 0) ? fixedLat[k] : int'($urandom_range(20, 1))) - 1;
                issuedCores.push_back(k);
                issueCount++;
            end
            reqHs[k] = 1'b0;
            resHs[k] = 1'b0;
        end
        if (spurThisCycle) expErr = 1'b1;
        driveInputs();
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        updateModels();
    endtask

    task automatic checkResetState();
        checkVal("rst_busy", 32'(busy), 0);
        checkVal("rst_tvalid", 32'(bus.out_tvalid), 0);
        checkVal("rst_tdata", 32'(bus.out_tdata), 0);
        checkVal("rst_tuser", 32'(bus.out_tuser), 0);
        checkVal("rst_tlast", 32'(bus.out_tlast), 0);
        checkVal("rst_req_valid", 32'(bus.core_req_valid), 0);
        checkVal("rst_res_ready", 32'(bus.core_res_ready), 0);
        checkVal("rst_frame_count", 32'(frameCount), 0);
        checkVal("rst_err", 32'(errSpurious), 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearModels();
        driveInputs();
        #1;
        checkResetState();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitBeats(int target);
        int n;
        n = 0;
        while (beatCount < target && n < BUDGET) begin
            applyStimulus();
            n++;
        end
        checkVal("beats_reached", beatCount, target);
    endtask

    task automatic waitFrames(int target);
        int n;
        n = 0;
        while (int'(frameCount) != target && n < BUDGET) begin
            applyStimulus();
            n++;
        end
        checkVal("frame_count", 32'(frameCount), target);
    endtask

    task automatic setLatency(int l0, int l1, int l2, int l3);
        fixedLat[0] = l0;
        fixedLat[1] = l1;
        fixedLat[2] = l2;
        fixedLat[3] = l3;
    endtask

    initial begin
        setLatency(3, 3, 3, 3);
        randReady = 1'b0;
        treadyPct = 100;
        clearModels();
        driveInputs();

        $display("[TB] scenario 1: fixed latency, back-to-back frames");
        doReset();
        enable = 1'b1;
        waitBeats(FRAME);
        waitFrames(1);
        waitBeats(2 * FRAME);
        waitFrames(2);

        $display("[TB] scenario 2: slow core 0, fast cores 1-3");
        setLatency(20, 1, 1, 1);
        doReset();
        enable = 1'b1;
        waitBeats(FRAME);
        waitFrames(1);

        $display("[TB] scenario 3: random latency and stream back-pressure");
        setLatency(0, 0, 0, 0);
        randReady = 1'b1;
        treadyPct = 50;
        doReset();
        enable = 1'b1;
        waitBeats(2 * FRAME);
        waitFrames(2);

        $display("[TB] scenario 4: enable dropped mid-frame");
        treadyPct = 70;
        doReset();
        enable = 1'b1;
        waitBeats(5);
        enable = 1'b0;
        waitBeats(FRAME);
        waitFrames(1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkVal("idle_busy", 32'(busy), 0);
            checkVal("idle_req_valid", 32'(bus.core_req_valid), 0);
        end
        checkVal("idle_no_extra_beats", beatCount, FRAME);

        $display("[TB] scenario 5: reset mid-frame");
        treadyPct = 100;
        doReset();
        enable = 1'b1;
        waitBeats(12);
        #2;
        rst = 1'b1;
        #1;
        checkResetState();
        clearModels();
        driveInputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitBeats(FRAME);
        waitFrames(1);

        $display("[TB] scenario 6: spurious result");
        treadyPct = 50;
        doReset();
        injectSpur = 1'b1;
        driveInputs();
        applyStimulus();
        injectSpur = 1'b0;
        driveInputs();
        applyStimulus();
        checkVal("spur_no_beat", 32'(bus.out_tvalid), 0);
        enable = 1'b1;
        waitBeats(FRAME);
        waitFrames(1);
        checkVal("err_sticky", 32'(errSpurious), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pixel_core_scheduler.md
Name: pixel_core_scheduler

Overview:
Sequences full-frame pixel rendering across NUM_CORES fractal iteration cores. Scans (x,y) in raster order and issues coordinates to cores in strict round-robin order. Retires results in the same order, so the output is raster ordered. Results drive an AXI4-Stream pixel output with tuser (SOF) on the first pixel and tlast (EOL) on the last pixel of each line; the stream feeds the video packer.

Parameters:
NUM_CORES, 4, number of iteration cores (2..16)
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
RES_W, 24, core result width (packed RGB)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enable  in  1  level; high = render frames back-to-back
core_req_valid  out  NUM_CORES  per-core job valid
core_req_ready  in  NUM_CORES  per-core job accept
core_req_x  out  10  job x (shared bus, qualified by core_req_valid)
core_req_y  out  9  job y (shared bus)
core_res_valid  in  NUM_CORES  per-core result valid
core_res_data  in  NUM_CORES*RES_W  packed results, core k at [k*RES_W +: RES_W]
core_res_ready  out  NUM_CORES  per-core result accept
out_tdata  out  RES_W  pixel
out_tvalid  out  1  stream valid
out_tready  in  1  stream ready
out_tuser  out  1  SOF
out_tlast  out  1  EOL
busy  out  1  state != IDLE
frame_count  out  16  completed frames, wraps at 65535->0
err_spurious  out  1  sticky: result valid from a core with no pending job

Behaviour:
- Reset values:
  - State IDLE.
  - Issue pointer ip=0; retire pointer rp=0.
  - Issue coords ix=0, iy=0; pending[]=0.
  - All outputs 0.
  - A reset mid-frame discards all in-flight work; the cores share rst.
- State IDLE:
  - enable=1 -> RUN next cycle, with ix=iy=0.
- State RUN:
  - core_req_valid = one-hot(ip) when !pending[ip]; otherwise 0. core_req_x/y = ix/iy.
  - Issue handshake when core_req_valid[ip] && core_req_ready[ip]:
    - Record tag_x[ip]=ix, tag_y[ip]=iy and set pending[ip].
    - Advance ip mod NUM_CORES and ix raster (ix wraps at X_SIZE-1, then iy++).
  - After issuing (X_SIZE-1, Y_SIZE-1) -> DRAIN.
  - Max issue rate: 1 job/cycle.
- State DRAIN:
  - No issues.
  - When pending==0 and out_tvalid==0: frame_count++.
  - Then go to RUN (ix=iy=0) if enable, else IDLE.
  - enable deasserted during RUN takes effect only at frame end; a frame is never truncated.
- Retire:
  - core_res_ready[rp] = pending[rp] && (!out_tvalid || out_tready). All other bits are 0.
  - On a result handshake:
    - out_tdata <= result of core rp; out_tvalid <= 1.
    - out_tuser <= (tag_x==0 && tag_y==0); out_tlast <= (tag_x==X_SIZE-1).
    - Clear pending[rp] and advance rp.
  - Latency: result handshake at cycle t -> out_tvalid at t+1.
  - Issue and retire to the same core in the same cycle: retire takes effect first. pending is not re-set until the following cycle's issue, because core_req_valid depends on the registered pending.
  - Results arriving from core k != rp are held by the core (ready=0) until rp==k.
- Stream:
  - out_* hold stable while out_tvalid && !out_tready.
  - out_tvalid drops after the beat is accepted unless a new result loads in the same cycle.
- err_spurious:
  - Set when core_res_valid[k] && !pending[k] for any k.
  - Cleared only by rst.
- Width:
  - ix/iy are 10/9 bits; X_SIZE <= 1024 and Y_SIZE <= 512 are enforced by elaboration assertion.
  - Pointers are clog2(NUM_CORES) bits.

Test Plan:
All scenarios use NUM_CORES=4, X_SIZE=8, Y_SIZE=4, with core models of variable latency (1-20 cycles) unless stated.
1. Fixed core latency 3, out_tready=1, enable held -> 32 beats per frame in raster order. tuser on beat 0 only; tlast on beats 7,15,23,31. frame_count 0->1->2.
2. Core 0 latency 20, cores 1-3 latency 1 -> output order remains (0,0),(1,0),(2,0),... No reordering. core_res_ready[1] stays low until core 0 retires.
3. out_tready random 50% -> no beat lost or duplicated; tdata/tuser/tlast stable while stalled; total of 32 beats per frame.
4. enable dropped at beat 5 of frame 0 -> frame completes all 32 beats, frame_count=1, then IDLE with busy=0 and no further core_req_valid.
5. rst pulsed mid-frame at beat 12 -> all outputs 0 the same cycle (asynchronous). After release with enable=1, next beat has tuser=1 and coords (0,0).
6. Inject core_res_valid[2] with no pending job -> err_spurious=1 and stays 1; stream contents unaffected.
